mem_port_ctrl: RTL and testbench



---
 rtl/mem_port_pkg.sv | 51 +++++
 rtl/mem_word_array.sv | 44 ++++
 rtl/mem_port_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_pkg
//   Shared types and helpers for the memory-port controller:
//     state_e     : controller FSM states (IDLE / WAIT / RESP)
//     op_e        : latched request kind (RD / WR / BAD)
//     WORD_W      : data word width
//     addr_ok()   : alignment + range check of a byte address for a DEPTH-word array
//     decode_op() : classifies an incoming request into op_e
// -----------------------------------------------------------------------------
package mem_port_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RD  = 2'd0,
        WR  = 2'd1,
        BAD = 2'd2
    } op_e;

    // True when the byte address is word aligned and falls inside the array.
    // Every bit above the word index must be clear.
    function automatic logic addr_ok(input logic [WORD_W-1:0] addr,
                                     input int unsigned       depth);
        int unsigned aw;
        aw = $clog2(depth);
        return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == '0);
    endfunction

    // Classifies a request that has rden and/or wren asserted.
    // Simultaneous read and write is treated as malformed.
    function automatic op_e decode_op(input logic rden,
                                      input logic wren,
                                      input logic ok);
        op_e op;
        if ((rden && wren) || !ok) begin
            op = BAD;
        end else if (wren) begin
            op = WR;
        end else begin
            op = RD;
        end
        return op;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// -----------------------------------------------------------------------------
// mem_word_array
//   DEPTH x WORD_W storage. One access per enabled cycle:
//     en_i & we_i  : mem[addr_i] <= wdata_i
//     en_i & !we_i : rdata_o     <= mem[addr_i]   (registered read)
//   rdata_o holds its value whenever no read is performed. No reset: the
//   contents and the read register survive controller reset.
// Ports:
//   clk_i    in   clock
//   en_i     in   access enable
//   we_i     in   1 = write, 0 = read (qualified by en_i)
//   addr_i   in   word index
//   wdata_i  in   write data
//   rdata_o  out  registered read data
// -----------------------------------------------------------------------------
module mem_word_array
    import mem_port_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WORD_W-1:0]        wdata_i,
    output logic [WORD_W-1:0]        rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// mem_port_ctrl
//   Fixed-latency memory controller for the core's shared memory port.
//   A request (rden or wren high) seen in IDLE is latched; the array access
//   happens at the edge entering RESP, and RESP lasts one cycle with a
//   memory_response pulse. The whole transaction occupies LATENCY cycles
//   (WAIT for LATENCY-1 cycles, then RESP); busy is high for all of them and
//   inputs are ignored meanwhile. The next request can be taken on the first
//   edge seen in IDLE, so accepted requests are at least LATENCY+1 cycles apart.
//
//   Handshake: the requester holds rden/wren as a level; the controller takes
//   it on an IDLE edge, then ignores all inputs while busy. memory_response is
//   a single-cycle pulse; err and memory_read_val are meaningful with it. A
//   request still high during RESP is taken again as a new request.
//
// Ports:
//   clk               in   clock, rising edge
//   reset             in   asynchronous active-high reset
//   memory_addr       in   byte address
//   memory_rden       in   read request (level)
//   memory_wren       in   write request (level)
//   memory_write_val  in   write data
//   memory_read_val   out  read data, held between responses, 0 after a malformed one
//   memory_response   out  one-cycle completion pulse
//   busy              out  request in flight
//   err               out  completed request was malformed (with memory_response)
//   dbg_state         out  current FSM state (state_e encoding)
// -----------------------------------------------------------------------------
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] memory_addr,
    input  logic              memory_rden,
    input  logic              memory_wren,
    input  logic [WORD_W-1:0] memory_write_val,
    output logic [WORD_W-1:0] memory_read_val,
    output logic              memory_response,
    output logic              busy,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Counter only has to hold LATENCY-1.
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    // FSM and request latch
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    op_e               op_q, op_d;

    // Registered outputs
    logic              resp_q;
    logic              busy_q;
    logic              err_q;
    logic              rd_valid_q;

    // Combinational helpers
    op_e               req_op;
    logic              fire;      // this edge enters RESP
    logic              arr_en;
    logic              arr_we;
    logic [WORD_W-1:0] arr_rdata;

    assign req_op = decode_op(memory_rden, memory_wren, addr_ok(memory_addr, DEPTH));

    // -------------------------------------------------------------------------
    // Next-state / latch logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        fire    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (memory_rden || memory_wren) begin
                    idx_d   = memory_addr[AW+1:2];
                    wdata_d = memory_write_val;
                    op_d    = req_op;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        fire    = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                    fire    = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            op_q       <= RD;
            resp_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            busy_q  <= (state_d != IDLE);
            resp_q  <= fire;
            err_q   <= fire && (op_d == BAD);
            // rd_valid_q selects the array read register onto memory_read_val.
            // A good read sets it, a malformed request clears it (read value 0),
            // a write leaves it so the previous read data stays visible.
            if (fire) begin
                if (op_d == BAD) begin
                    rd_valid_q <= 1'b0;
                end else if (op_d == RD) begin
                    rd_valid_q <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage: accessed only on the edge entering RESP, for well-formed requests.
    // The _d request fields cover both the direct IDLE->RESP path (LATENCY=1)
    // and the WAIT->RESP path. Gated by reset because the array has none and
    // would otherwise accept a write while the controller is held in reset.
    // -------------------------------------------------------------------------
    assign arr_en = fire && (op_d != BAD) && !reset;
    assign arr_we = (op_d == WR);

    mem_word_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk),
        .en_i    (arr_en),
        .we_i    (arr_we),
        .addr_i  (idx_d),
        .wdata_i (wdata_d),
        .rdata_o (arr_rdata)
    );

    // Both operands are flops, so no input reaches an output combinationally.
    assign memory_read_val = rd_valid_q ? arr_rdata : '0;
    assign memory_response = resp_q;
    assign busy            = busy_q;
    assign err             = err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
module tb_mem_port_ctrl;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (LATENCY=2)
  logic [31:0] addr, wval, rval;
  logic        rden, wren, resp, busy, err;
  logic [1:0]  dbg_state;

  // Second DUT (LATENCY=1) for back-to-back behaviour
  logic [31:0] addr1, wval1, rval1;
  logic        rden1, wren1, resp1, busy1, err1;
  logic [1:0]  dbg_state1;

  mem_port_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk              (clk),
    .reset            (reset),
    .memory_addr      (addr),
    .memory_rden      (rden),
    .memory_wren      (wren),
    .memory_write_val (wval),
    .memory_read_val  (rval),
    .memory_response  (resp),
    .busy             (busy),
    .err              (err),
    .dbg_state        (dbg_state)
  );

  mem_port_ctrl #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk              (clk),
    .reset            (reset),
    .memory_addr      (addr1),
    .memory_rden      (rden1),
    .memory_wren      (wren1),
    .memory_write_val (wval1),
    .memory_read_val  (rval1),
    .memory_response  (resp1),
    .busy             (busy1),
    .err              (err1),
    .dbg_state        (dbg_state1)
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_rd = 32'h0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Malformed: misaligned, beyond the array, or both read and write.
  function automatic logic is_bad(input logic rd, input logic wr, input logic [31:0] a);
    return (rd && wr) || (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one full transaction on the main DUT. Called at a negedge with the
  // DUT idle. junk_a is driven (with wren=1) while busy to prove it is ignored.
  // ---------------------------------------------------------------------------
  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] junk_a);
    logic        exp_err;
    logic [31:0] exp_val;
    exp_err = is_bad(rd, wr, a);
    if (exp_err) last_rd = 32'h0;
    else if (wr) model_mem[a / 4] = d;
    else         last_rd = model_mem[a / 4];
    exp_q.push_back(last_rd);

    rden = rd; wren = wr; addr = a; wval = d;
    @(posedge clk);                       // acceptance edge
    @(negedge clk);
    for (int i = 0; i < LAT - 1; i++) begin
      check("busy_wait", {31'b0, busy}, 32'd1);
      check("resp_wait", {31'b0, resp}, 32'd0);
      rden = $urandom_range(0, 1); wren = 1'b1; addr = junk_a; wval = $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    rden = 1'b0; wren = 1'b0;
    exp_val = exp_q.pop_front();
    check("resp_pulse", {31'b0, resp}, 32'd1);
    check("busy_resp",  {31'b0, busy}, 32'd1);
    check("err",        {31'b0, err},  {31'b0, exp_err});
    check("read_val",   rval, exp_val);
    @(posedge clk);
    @(negedge clk);
    check("resp_end", {31'b0, resp}, 32'd0);
    check("busy_end", {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] rand_good_addr();
    return 32'($urandom_range(0, DEPTH - 1)) * 4;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] a;
    logic        rd;
    rden = 0; wren = 0; addr = 0; wval = 0;
    rden1 = 0; wren1 = 0; addr1 = 0; wval1 = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rval", rval, 32'h0);
    check("rst_resp", {31'b0, resp}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err",  {31'b0, err},  32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 32'd0);

    // Fill the array so every later read has a known model value.
    for (int i = 0; i < DEPTH; i++) req(1'b0, 1'b1, 32'(i) * 4, $urandom, rand_good_addr());

    // Write then read.
    req(1'b0, 1'b1, 32'h10, 32'hCAFEBABE, 32'h14);
    req(1'b1, 1'b0, 32'h10, 32'h0, 32'h14);
    check("cafe_readback", rval, 32'hCAFEBABE);

    // Malformed requests.
    req(1'b1, 1'b0, 32'h13, 32'h0, 32'h10);
    req(1'b0, 1'b1, 32'h13, 32'h11111111, 32'h10);
    req(1'b1, 1'b0, 32'h10, 32'h0, 32'h10);
    req(1'b1, 1'b0, 32'h400, 32'h0, 32'h10);
    req(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h10);
    req(1'b1, 1'b0, 32'h10, 32'h0, 32'h10);
    check("no_bad_write", rval, 32'hCAFEBABE);

    // Busy-ignore: junk write to 0x0C while reading 0x08.
    req(1'b1, 1'b0, 32'h08, 32'h0, 32'h0C);
    req(1'b1, 1'b0, 32'h0C, 32'h0, 32'h08);

    // Last word.
    req(1'b0, 1'b1, 32'h3FC, 32'hFFFFFFFF, 32'h3F8);
    req(1'b1, 1'b0, 32'h3FC, 32'h0, 32'h3F8);

    // Random mix, occasionally malformed.
    for (int n = 0; n < 300; n++) begin
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : rand_good_addr();
      rd = 1'($urandom_range(0, 1));
      req(rd, ($urandom_range(0, 15) == 0) ? 1'b1 : ~rd, a, $urandom,
          ($urandom_range(0, 1) == 1) ? rand_good_addr() : 32'($urandom));
    end

    // LATENCY=1 instance: re-request held across RESP is taken again.
    wren1 = 1'b1; addr1 = 32'h04; wval1 = 32'hA5A50004;
    @(posedge clk);
    @(negedge clk);
    check("l1_wr_resp", {31'b0, resp1}, 32'd1);
    check("l1_wr_err",  {31'b0, err1},  32'd0);
    wren1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("l1_idle_busy", {31'b0, busy1}, 32'd0);
    rden1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("l1_busy", {31'b0, busy1}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("l1_resp", {31'b0, resp1}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) check("l1_rval", rval1, 32'hA5A50004);
    end
    rden1 = 1'b0;

    // Reset in the middle of a write to 0x20.
    wren = 1'b1; addr = 32'h20; wval = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    wren = 1'b0;
    #1;
    check("mid_rst_rval", rval, 32'h0);
    check("mid_rst_resp", {31'b0, resp}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_err",  {31'b0, err},  32'd0);
    last_rd = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("mid_no_resp", {31'b0, resp}, 32'd0);
    end
    req(1'b1, 1'b0, 32'h20, 32'h0, 32'h24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
